// File: rtl/exu_alu_core.sv
// exu_alu_core: EXU ALU datapath with valid/ready on both sides.
// Single-cycle ops finish in one cycle; shifts move one bit per cycle.
module exu_alu_core #(
  parameter int ISA_WIDTH       = 32,
  parameter int SHAMT_WIDTH     = 5,
  parameter int ALU_FUNCT_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ISA_WIDTH-1:0]       alu_a,
  input  logic [ISA_WIDTH-1:0]       alu_b,
  input  logic [ALU_FUNCT_WIDTH-1:0] alu_funct,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ISA_WIDTH-1:0]       alu_result,
  output logic                       busy
);

  localparam logic [ALU_FUNCT_WIDTH-1:0] F_ADD      = 4'd0;
  localparam logic [ALU_FUNCT_WIDTH-1:0] F_SUB      = 4'd1;
  localparam logic [ALU_FUNCT_WIDTH-1:0] F_EQ       = 4'd2;
  localparam logic [ALU_FUNCT_WIDTH-1:0] F_NEQ      = 4'd3;
  localparam logic [ALU_FUNCT_WIDTH-1:0] F_LESS_U   = 4'd4;
  localparam logic [ALU_FUNCT_WIDTH-1:0] F_LESS_S   = 4'd5;
  localparam logic [ALU_FUNCT_WIDTH-1:0] F_AND      = 4'd6;
  localparam logic [ALU_FUNCT_WIDTH-1:0] F_OR       = 4'd7;
  localparam logic [ALU_FUNCT_WIDTH-1:0] F_XOR      = 4'd8;
  localparam logic [ALU_FUNCT_WIDTH-1:0] F_SHIFT_LL = 4'd9;
  localparam logic [ALU_FUNCT_WIDTH-1:0] F_SHIFT_RL = 4'd10;
  localparam logic [ALU_FUNCT_WIDTH-1:0] F_SHIFT_RA = 4'd11;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [SHAMT_WIDTH-1:0] SH_ZERO = '0;
  localparam logic [SHAMT_WIDTH-1:0] SH_ONE  =
    {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]                 state;
  logic [ISA_WIDTH-1:0]       a_q;
  logic [ALU_FUNCT_WIDTH-1:0] funct_q;
  logic [SHAMT_WIDTH-1:0]     count_q;

  logic [SHAMT_WIDTH-1:0]     shamt;
  logic                       is_shift;
  logic                       flag;
  logic [ISA_WIDTH-1:0]       single_res;
  logic [ISA_WIDTH-1:0]       shift_next;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign shamt     = alu_b[SHAMT_WIDTH-1:0];

  assign is_shift = (alu_funct == F_SHIFT_LL) ||
                    (alu_funct == F_SHIFT_RL) ||
                    (alu_funct == F_SHIFT_RA);

  // One-cycle result; a zero-amount shift passes operand A through.
  always_comb begin
    flag       = 1'b0;
    single_res = '0;
    case (alu_funct)
      F_ADD:      single_res = alu_a + alu_b;
      F_SUB:      single_res = alu_a - alu_b;
      F_EQ:       flag = (alu_a == alu_b);
      F_NEQ:      flag = (alu_a != alu_b);
      F_LESS_U:   flag = (alu_a < alu_b);
      F_LESS_S:   flag = ($signed(alu_a) < $signed(alu_b));
      F_AND:      single_res = alu_a & alu_b;
      F_OR:       single_res = alu_a | alu_b;
      F_XOR:      single_res = alu_a ^ alu_b;
      F_SHIFT_LL: single_res = alu_a;
      F_SHIFT_RL: single_res = alu_a;
      F_SHIFT_RA: single_res = alu_a;
      default:    single_res = '0;
    endcase
    if (flag)
      single_res = {{(ISA_WIDTH-1){1'b0}}, 1'b1};
  end

  // One-bit step of the working register for the latched shift kind.
  always_comb begin
    shift_next = a_q;
    case (funct_q)
      F_SHIFT_LL: shift_next = {a_q[ISA_WIDTH-2:0], 1'b0};
      F_SHIFT_RL: shift_next = {1'b0, a_q[ISA_WIDTH-1:1]};
      F_SHIFT_RA: shift_next = {a_q[ISA_WIDTH-1], a_q[ISA_WIDTH-1:1]};
      default:    shift_next = a_q;
    endcase
  end

  // Control FSM, operand latch, shift iteration and result register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      a_q        <= '0;
      funct_q    <= '0;
      count_q    <= '0;
      alu_result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= alu_a;
            funct_q <= alu_funct;
            count_q <= shamt;
            if (is_shift && (shamt != SH_ZERO)) begin
              state <= S_SHIFT;
            end else begin
              alu_result <= single_res;
              state      <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          a_q     <= shift_next;
          count_q <= count_q - SH_ONE;
          if (count_q == SH_ONE) begin
            alu_result <= shift_next;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exu_alu_core.sv
// tb_exu_alu_core: directed vectors for exu_alu_core.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_exu_alu_core;

  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_SUB  = 4'd1;
  localparam logic [3:0] F_EQ   = 4'd2;
  localparam logic [3:0] F_NEQ  = 4'd3;
  localparam logic [3:0] F_LTU  = 4'd4;
  localparam logic [3:0] F_LTS  = 4'd5;
  localparam logic [3:0] F_AND  = 4'd6;
  localparam logic [3:0] F_OR   = 4'd7;
  localparam logic [3:0] F_XOR  = 4'd8;
  localparam logic [3:0] F_SLL  = 4'd9;
  localparam logic [3:0] F_SRL  = 4'd10;
  localparam logic [3:0] F_SRA  = 4'd11;
  localparam logic [3:0] F_UNDF = 4'd12;
  localparam logic [3:0] F_NONE = 4'd15;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_funct;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  exu_alu_core dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_funct  (alu_funct),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op with out_ready=1; result expected lat cycles later.
  task automatic op(input string tag,
                    input logic [3:0] f,
                    input logic [31:0] a,
                    input logic [31:0] b,
                    input logic [31:0] exp,
                    input int lat);
    alu_funct = f;
    alu_a     = a;
    alu_b     = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 1; i < lat; i++) begin
      chk({tag, "_wait_valid"}, {31'b0, out_valid}, 32'd0);
      step();
    end
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_result"}, alu_result, exp);
    step();
    chk({tag, "_consumed"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b1;
    alu_a     = 32'h0000_1234;
    alu_b     = 32'h0000_0001;
    alu_funct = F_ADD;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", alu_result, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);

    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    chk("idle_out_valid", {31'b0, out_valid}, 32'd0);

    alu_funct = F_ADD;
    alu_a     = 32'hFFFF_FFFF;
    alu_b     = 32'h0000_0001;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_result", alu_result, 32'h0000_0000);
    chk("add_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    chk("add_consumed", {31'b0, out_valid}, 32'd0);
    chk("add_idle_ready", {31'b0, in_ready}, 32'd1);

    op("lts", F_LTS, 32'h8000_0000, 32'h1, 32'h1, 1);
    op("ltu", F_LTU, 32'h8000_0000, 32'h1, 32'h0, 1);
    op("eq", F_EQ, 32'h5, 32'h5, 32'h1, 1);
    op("neq", F_NEQ, 32'h5, 32'h5, 32'h0, 1);
    op("and", F_AND, 32'hF0F0_1234, 32'h0FF0_FF00,
       32'h00F0_1200, 1);
    op("or", F_OR, 32'hF0F0_1234, 32'h0FF0_FF00,
       32'hFFF0_FF34, 1);
    op("xor", F_XOR, 32'hF0F0_1234, 32'h0FF0_FF00,
       32'hFF00_ED34, 1);
    op("none", F_NONE, 32'h1, 32'h1, 32'h0, 1);
    op("undef", F_UNDF, 32'h7, 32'h3, 32'h0, 1);
    op("sra3", F_SRA, 32'h8000_0000, 32'h0000_0023,
       32'hF000_0000, 4);
    op("sra_pos", F_SRA, 32'h4000_0000, 32'h2,
       32'h1000_0000, 3);
    op("srl4", F_SRL, 32'h8000_0000, 32'h4,
       32'h0800_0000, 5);
    op("sll_hib", F_SLL, 32'h1, 32'hFFFF_FFE4,
       32'h0000_0010, 5);
    op("sll0", F_SLL, 32'hDEAD_BEEF, 32'h20,
       32'hDEAD_BEEF, 1);

    alu_funct = F_SUB;
    alu_a     = 32'd5;
    alu_b     = 32'd7;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    alu_funct = F_ADD;
    alu_a     = 32'd2;
    alu_b     = 32'd3;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_result", alu_result, 32'hFFFF_FFFE);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_released", {31'b0, out_valid}, 32'd0);
    chk("bp_idle_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_hold_result", alu_result, 32'hFFFF_FFFE);
    step();
    in_valid = 1'b0;
    chk("held_valid", {31'b0, out_valid}, 32'd1);
    chk("held_result", alu_result, 32'd5);
    step();
    chk("held_consumed", {31'b0, out_valid}, 32'd0);

    alu_funct = F_SLL;
    alu_a     = 32'h1;
    alu_b     = 32'd31;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) begin
      chk("ms_no_valid", {31'b0, out_valid}, 32'd0);
      chk("ms_busy", {31'b0, busy}, 32'd1);
      step();
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("ms_in_ready", {31'b0, in_ready}, 32'd1);
    chk("ms_busy_clr", {31'b0, busy}, 32'd0);
    chk("ms_result_clr", alu_result, 32'd0);
    for (int i = 0; i < 30; i++) begin
      chk("ms_no_pulse", {31'b0, out_valid}, 32'd0);
      step();
    end

    op("post_rst", F_ADD, 32'd2, 32'd3, 32'd5, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
